// File: rtl/voice_scheduler.sv
// Time-multiplexed 4-voice phase-accumulator oscillator scheduler.
// Each voice reads one sample from a shared ROM, and the summed result is emitted once per sample frame.
module voice_scheduler #(
  parameter int unsigned NVOICE = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Sample_tick,
  input  logic [23:0]       Phase_inc0,
  input  logic [23:0]       Phase_inc1,
  input  logic [23:0]       Phase_inc2,
  input  logic [23:0]       Phase_inc3,
  input  logic [NVOICE-1:0] Voice_en,
  output logic [11:0]       Rom_addr,
  input  logic [15:0]       Rom_data,
  output logic [15:0]       Mix_out,
  output logic              Mix_valid,
  output logic              Busy,
  output logic              Overrun
);

  localparam int unsigned PW   = 24;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 16;
  localparam int unsigned ACCW = 18;
  localparam int unsigned VW   = $clog2(NVOICE);

  typedef enum logic [3:0] {
    IDLE, ADDR0, ACC0, ADDR1, ACC1, ADDR2, ACC2, ADDR3, ACC3, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q [NVOICE];
  logic [PW-1:0]   phase_d [NVOICE];
  logic [PW-1:0]   inc     [NVOICE];
  logic [ACCW-1:0] acc_q, acc_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [DW-1:0]   mix_out_q, mix_out_d;
  logic            mix_valid_q, mix_valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic [VW-1:0]   vidx;
  logic            is_acc;

  assign inc[0] = Phase_inc0;
  assign inc[1] = Phase_inc1;
  assign inc[2] = Phase_inc2;
  assign inc[3] = Phase_inc3;

  // Voice served by the current ADDRi/ACCi slot
  always_comb begin
    vidx   = '0;
    is_acc = 1'b0;
    unique case (state_q)
      ADDR1, ACC1: vidx = VW'(1);
      ADDR2, ACC2: vidx = VW'(2);
      ADDR3, ACC3: vidx = VW'(3);
      default:     vidx = '0;
    endcase
    if (state_q inside {ACC0, ACC1, ACC2, ACC3}) is_acc = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    mix_out_d  = mix_out_q;
    overrun_d  = overrun_q | (Sample_tick & (state_q != IDLE));

    // Rom_addr is loaded on entry to ADDRi so the ROM word arrives during ACCi
    unique case (state_q)
      IDLE: begin
        if (Sample_tick) begin
          state_d    = ADDR0;
          rom_addr_d = phase_q[0][PW-1 -: AW];
        end
      end
      ADDR0: begin
        state_d = ACC0;
        acc_d   = '0;
      end
      ACC0: begin
        state_d    = ADDR1;
        rom_addr_d = phase_q[1][PW-1 -: AW];
      end
      ADDR1: state_d = ACC1;
      ACC1: begin
        state_d    = ADDR2;
        rom_addr_d = phase_q[2][PW-1 -: AW];
      end
      ADDR2: state_d = ACC2;
      ACC2: begin
        state_d    = ADDR3;
        rom_addr_d = phase_q[3][PW-1 -: AW];
      end
      ADDR3:   state_d = ACC3;
      ACC3:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (is_acc) begin
      if (Voice_en[vidx]) begin
        acc_d         = acc_d + {{(ACCW-DW){Rom_data[DW-1]}}, Rom_data};
        phase_d[vidx] = phase_q[vidx] + inc[vidx];
      end else begin
        phase_d[vidx] = '0;
      end
    end

    // Four 16-bit terms fit 18 bits exactly, so >>>2 never overflows 16 bits
    if (state_q == ACC3) mix_out_d = acc_d[ACCW-1 -: DW];

    mix_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '{default: '0};
      acc_q       <= '0;
      rom_addr_q  <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      rom_addr_q  <= rom_addr_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign Rom_addr  = rom_addr_q;
  assign Mix_out   = mix_out_q;
  assign Mix_valid = mix_valid_q;
  assign Busy      = busy_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a reference model predicts each frame's mix and ADDR0 address.
module tb_voice_scheduler;

  logic        Clk;
  logic        Reset_n;
  logic        Sample_tick;
  logic [23:0] inc [4];
  logic [3:0]  Voice_en;
  logic [11:0] Rom_addr;
  logic [15:0] Rom_data;
  logic [15:0] Mix_out;
  logic        Mix_valid;
  logic        Busy;
  logic        Overrun;

  typedef struct {
    logic [15:0] mix;
    logic [11:0] addr0;
    int          tcyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pcyc     = 0;
  int          nvalid   = 0;
  logic [23:0] m_phase [4];
  int          rom_mode = 0;
  logic [15:0] rom_const = 16'h0000;

  voice_scheduler #(.NVOICE(4)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Sample_tick(Sample_tick),
    .Phase_inc0 (inc[0]),
    .Phase_inc1 (inc[1]),
    .Phase_inc2 (inc[2]),
    .Phase_inc3 (inc[3]),
    .Voice_en   (Voice_en),
    .Rom_addr   (Rom_addr),
    .Rom_data   (Rom_data),
    .Mix_out    (Mix_out),
    .Mix_valid  (Mix_valid),
    .Busy       (Busy),
    .Overrun    (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) pcyc <= pcyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rom_fn(input logic [11:0] a);
    case (rom_mode)
      0:       return {4'h0, a};
      1:       return rom_const;
      default: return {a, a[11:8]};
    endcase
  endfunction

  // Synchronous ROM: word for the presented address arrives one cycle later
  always @(posedge Clk) Rom_data <= rom_fn(Rom_addr);

  function automatic exp_t model_frame();
    exp_t              e;
    logic signed [17:0] acc;
    logic [15:0]        d;
    acc     = '0;
    e.addr0 = m_phase[0][23:12];
    e.tcyc  = 0;
    for (int i = 0; i < 4; i++) begin
      d = rom_fn(m_phase[i][23:12]);
      if (Voice_en[i]) begin
        acc        = acc + 18'(signed'(d));
        m_phase[i] = m_phase[i] + inc[i];
      end else begin
        m_phase[i] = '0;
      end
    end
    e.mix = acc[17:2];
    return e;
  endfunction

  logic        busy_prev = 1'b0;
  logic [11:0] cur_addr0 = '0;
  always @(negedge Clk) begin
    exp_t e;
    if (Busy === 1'b1 && busy_prev !== 1'b1) cur_addr0 = Rom_addr;
    busy_prev = Busy;
    if (Mix_valid === 1'b1) begin
      nvalid++;
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("mix_out", 32'(Mix_out), 32'(e.mix));
        check("addr0", 32'(cur_addr0), 32'(e.addr0));
        check("latency", 32'(pcyc - e.tcyc), 32'd9);
      end
    end
  end

  // Caller is at a negedge; tick is sampled on the following posedge
  task automatic start_frame();
    exp_t e;
    e      = model_frame();
    e.tcyc = pcyc;
    sb.push_back(e);
    Sample_tick = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge Clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("frame_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge Clk);
  endtask

  task automatic run_frame();
    @(negedge Clk);
    start_frame();
    @(negedge Clk);
    Sample_tick = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) m_phase[i] = '0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nv0;
    Reset_n     = 1'b0;
    Sample_tick = 1'b0;
    Voice_en    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      inc[i]     = '0;
      m_phase[i] = '0;
    end
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(Mix_valid), 32'd0);
    check("rst_mix", 32'(Mix_out), 32'd0);
    check("rst_addr", 32'(Rom_addr), 32'd0);
    check("rst_overrun", 32'(Overrun), 32'd0);
    Reset_n = 1'b1;

    // Single voice, ROM echoes address: ADDR0 walks 0,1,2 and mix stays 0
    rom_mode = 0;
    Voice_en = 4'h1;
    inc[0]   = 24'h001000;
    repeat (3) run_frame();

    // Full-scale constants across all four voices
    Voice_en = 4'hF;
    for (int i = 0; i < 4; i++) inc[i] = 24'(($urandom() & 32'h00FFFFFF));
    rom_mode  = 1;
    rom_const = 16'h4000;
    run_frame();
    rom_const = 16'h8000;
    run_frame();

    // Phase wrap on voice 0: 0 -> 0xFFF000 -> 0x001000
    do_reset();
    rom_mode = 0;
    Voice_en = 4'h1;
    inc[0]   = 24'hFFF000;
    run_frame();
    inc[0] = 24'h002000;
    run_frame();
    run_frame();

    // Random enables and increments with signed ROM content
    rom_mode = 2;
    for (int n = 0; n < 6; n++) begin
      Voice_en = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) inc[i] = 24'(($urandom() & 32'h00FFFFFF));
      run_frame();
    end
    Voice_en = 4'h0;
    run_frame();

    // Overrun: second tick four cycles into the frame is ignored
    check("overrun_pre", 32'(Overrun), 32'd0);
    Voice_en = 4'hF;
    nv0      = nvalid;
    @(negedge Clk);
    start_frame();
    @(negedge Clk);
    Sample_tick = 1'b0;
    repeat (3) @(negedge Clk);
    Sample_tick = 1'b1;
    @(negedge Clk);
    Sample_tick = 1'b0;
    check("overrun_set", 32'(Overrun), 32'd1);
    wait_idle();
    repeat (5) @(negedge Clk);
    check("overrun_valid_count", 32'(nvalid - nv0), 32'd1);
    run_frame();
    check("overrun_sticky", 32'(Overrun), 32'd1);
    do_reset();
    @(negedge Clk);
    check("overrun_cleared", 32'(Overrun), 32'd0);

    // Reset during ACC2 aborts the frame; tick on first released edge runs normally
    rom_mode  = 1;
    rom_const = 16'h4000;
    Voice_en  = 4'hF;
    run_frame();
    @(negedge Clk);
    start_frame();
    @(negedge Clk);
    Sample_tick = 1'b0;
    repeat (5) @(negedge Clk);
    check("busy_in_acc2", 32'(Busy), 32'd1);
    Reset_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) m_phase[i] = '0;
    @(negedge Clk);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_mix", 32'(Mix_out), 32'd0);
    check("midrst_valid", 32'(Mix_valid), 32'd0);
    check("midrst_addr", 32'(Rom_addr), 32'd0);
    rom_mode = 0;
    Reset_n  = 1'b1;
    start_frame();
    @(negedge Clk);
    Sample_tick = 1'b0;
    wait_idle();

    // Disabling voice 0 between frames forces its phase back to 0
    rom_mode = 2;
    Voice_en = 4'hF;
    inc[0]   = 24'h123456;
    inc[1]   = 24'h0ABCDE;
    inc[2]   = 24'h700001;
    inc[3]   = 24'hF00F00;
    run_frame();
    run_frame();
    Voice_en = 4'hE;
    run_frame();
    run_frame();

    repeat (4) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
